fifo_serial_tx: RTL and testbench

Drain-side counterpart of the byte-loading FIFO. The block pops bytes from the upstream FIFO whenever it is non-empty and serializes them MSB-first onto a single-bit stream. Consecutive bytes are grouped into frames marked with start-of-frame and end-of-frame flags. A ready/valid handshake toward the line or PHY stage lets the downstream stall the shifter.

---
 rtl/fifo_tx_pkg.sv | 21 ++
 rtl/fifo_serial_tx_if.sv | 28 ++
 rtl/fifo_tx_shifter.sv | 42 ++++
 rtl/fifo_serial_tx.sv | 100 ++++++++++
 tb/tb_fifo_serial_tx.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_tx_pkg.sv
// Shared types and defaults for the FIFO drain-side serializer.
// States, default widths and a counter-width helper used across the slice.
package fifo_tx_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    PAR
  } state_t;

  // Width of a counter indexing 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO pop port plus serial ready/valid stream of fifo_serial_tx.
// master: the serializer; slave: the FIFO and line stage around it.
interface fifo_serial_tx_if
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_data;
  logic              tx_ready;
  logic              tx_valid;
  logic              tx_bit;
  logic              tx_sof;
  logic              tx_eof;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_rd_en, tx_valid, tx_bit, tx_sof, tx_eof
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_rd_en, tx_valid, tx_bit, tx_sof, tx_eof
  );

endinterface

// File: rtl/fifo_tx_shifter.sv
// MSB-first load/shift register with bit counter and running even parity.
// The bit counter saturates on the last data bit so it never wraps mid-byte.
module fifo_tx_shifter
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BIT_W  = cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              parity
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shreg;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      parity  <= 1'b0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= '0;
      parity  <= 1'b0;
    end else if (shift) begin
      shreg  <= {shreg[DATA_W-2:0], 1'b0};
      parity <= parity ^ shreg[DATA_W-1];
      if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from the upstream FIFO and serializes them MSB-first in framed bursts.
// Optional even-parity beat per byte: define FIFO_TX_PARITY_EN.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BYTES = DEF_MAX_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  fifo_serial_tx_if.master  bus,
  output logic              busy
);

  localparam int BIT_W  = cnt_w(DATA_W);
  localparam int BYTE_W = cnt_w(MAX_BYTES);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(MAX_BYTES - 1);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] byte_cnt;
  logic              eof_hold;
  logic              load, shift;
  logic              msb, parity;
  logic [BIT_W-1:0]  bit_cnt;
  logic              beat, final_beat, last_byte;

  fifo_tx_shifter #(.DATA_W(DATA_W), .BIT_W(BIT_W)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .din     (bus.fifo_data),
    .msb     (msb),
    .bit_cnt (bit_cnt),
    .parity  (parity)
  );

  // eof_hold keeps a shown tx_eof stable while the final beat is stalled,
  // even if the FIFO is written meanwhile.
  assign last_byte = bus.fifo_empty || (byte_cnt == LAST_BYTE) || eof_hold;
  assign beat      = bus.tx_valid && bus.tx_ready;

`ifdef FIFO_TX_PARITY_EN
  assign final_beat = (state_q == PAR);
  assign bus.tx_bit = (state_q == SHIFT) ? msb : ((state_q == PAR) && parity);
`else
  assign final_beat = (state_q == SHIFT) && (bit_cnt == LAST_BIT);
  assign bus.tx_bit = (state_q == SHIFT) && msb;
  logic unused_parity;
  assign unused_parity = parity;
`endif

  assign bus.tx_valid   = (state_q == SHIFT) || (state_q == PAR);
  assign bus.tx_sof     = (state_q == SHIFT) && (bit_cnt == '0) && (byte_cnt == '0);
  assign bus.tx_eof     = final_beat && last_byte;
  assign bus.fifo_rd_en = (state_q == FETCH);
  assign busy           = (state_q != IDLE);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE:  if (!bus.fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (beat) begin
          shift = 1'b1;
`ifdef FIFO_TX_PARITY_EN
          if (bit_cnt == LAST_BIT) state_d = PAR;
`else
          if (bit_cnt == LAST_BIT) state_d = last_byte ? IDLE : FETCH;
`endif
        end
      end
      PAR:     if (beat) state_d = last_byte ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      byte_cnt <= '0;
      eof_hold <= 1'b0;
    end else begin
      state_q  <= state_d;
      eof_hold <= final_beat && !beat && last_byte;
      if (state_q == IDLE) byte_cnt <= '0;
      else if (final_beat && beat && !last_byte) byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Testbench for fifo_serial_tx: behavioural FIFO, stream monitor and frame model.
// Honours FIFO_TX_PARITY_EN when the DUT is built with it.
module tb_fifo_serial_tx;
  import fifo_tx_pkg::*;

  localparam int DW = 8;
  localparam int MB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BPB = DW + PB;

  typedef struct {
    logic b;
    logic sof;
    logic eof;
    int   cyc;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  fifo_serial_tx_if #(.DATA_W(DW)) bus ();

  fifo_serial_tx #(.DATA_W(DW), .MAX_BYTES(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] model_q[$];
  beat_t      got_q[$];
  beat_t      exp_q[$];
  int         rd_cyc[$];
  int cyc = 0, rd_cnt = 0, rd_empty = 0, hold_err = 0;
  int total = 0, bad = 0;
  logic  prev_stall = 1'b0;
  beat_t prev;

  // Upstream FIFO: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    cyc++;
    if (bus.fifo_rd_en === 1'b1) begin
      if (fifo_q.size() == 0) rd_empty++;
      else bus.fifo_data <= fifo_q.pop_front();
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t cur;
    cur = '{b: bus.tx_bit, sof: bus.tx_sof, eof: bus.tx_eof, cyc: cyc};
    if (bus.fifo_rd_en === 1'b1) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
    end
    if (prev_stall && (bus.tx_valid !== 1'b1 || cur.b !== prev.b ||
                       cur.sof !== prev.sof || cur.eof !== prev.eof))
      hold_err++;
    prev_stall = (reset === 1'b0) && (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
    prev = cur;
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) got_q.push_back(cur);
  end

  task automatic start_test();
    got_q.delete();
    model_q.delete();
    rd_cyc.delete();
    rd_cnt   = 0;
    hold_err = 0;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    model_q.push_back(d);
  endtask

  // Expected stream: bytes queued up front form frames of up to MB bytes.
  task automatic build_model();
    int n;
    n = model_q.size();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < BPB; j++) begin
        beat_t e;
        e.b   = (j < DW) ? model_q[i][DW-1-j] : ^model_q[i];
        e.sof = (i % MB == 0) && (j == 0);
        e.eof = (j == BPB - 1) && ((i % MB == MB - 1) || (i == n - 1));
        e.cyc = 0;
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic int stream_diff(output int first_idx);
    int n = 0;
    first_idx = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i].b !== exp_q[i].b || got_q[i].sof !== exp_q[i].sof ||
          got_q[i].eof !== exp_q[i].eof) begin
        if (first_idx < 0) first_idx = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic wait_idle(input bit rnd_ready, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      bus.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fifo_q.size() == 0 && busy === 1'b0 && bus.fifo_rd_en === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.fifo_rd_en, bus.tx_valid, bus.tx_bit, bus.tx_sof, bus.tx_eof, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {bus.fifo_rd_en, bus.tx_valid, bus.tx_bit, bus.tx_sof, bus.tx_eof, busy});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || rd_cnt !== 0) begin
      bad++;
      $display("FAIL idle_empty busy=%b pops=%0d exp busy=0 pops=0", busy, rd_cnt);
    end
  endtask

  task automatic test_single();
    bit to;
    int c, d, fi;
    logic [7:0] b35;
    b35 = 8'h35;
    start_test();
    bus.tx_ready = 1'b1;
    push(b35);
    build_model();
    c = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.fifo_empty === 1'b0) begin
        c = cyc;
        break;
      end
    end
    wait_idle(1'b0, 100, to);
    total++;
    if (to || c < 0) begin bad++; $display("FAIL single_timeout to=%0d c=%0d", to, c); end
    total++;
    if (rd_cyc.size() != 1 || rd_cyc[0] != c + 1) begin
      bad++;
      $display("FAIL single_pop pops=%0d first=%0d exp one pop at %0d", rd_cyc.size(),
               (rd_cyc.size() > 0) ? rd_cyc[0] : -1, c + 1);
    end
    total++;
    if (got_q.size() != BPB) begin
      bad++;
      $display("FAIL single_beats got=%0d exp=%0d", got_q.size(), BPB);
    end else begin
      total++;
      if (got_q[0].cyc != c + 3 || got_q[BPB-1].cyc != c + BPB + 2) begin
        bad++;
        $display("FAIL single_latency first=%0d last=%0d exp %0d..%0d", got_q[0].cyc,
                 got_q[BPB-1].cyc, c + 3, c + BPB + 2);
      end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got_q[i].b !== b35[7-i]) begin
          bad++;
          $display("FAIL single_bit%0d got=%b exp=%b", i, got_q[i].b, b35[7-i]);
        end
      end
    end
    d = stream_diff(fi);
    total++;
    if (d != 0) begin bad++; $display("FAIL single_flags diffs=%0d at beat %0d exp 0", d, fi); end
  endtask

  task automatic test_frame();
    bit to;
    int d, fi;
    start_test();
    push(8'h35); push(8'hAF); push(8'hE6);
    build_model();
    wait_idle(1'b0, 200, to);
    total++;
    if (to || got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL frame_beats to=%0d got=%0d exp=%0d", to, got_q.size(), exp_q.size());
    end else begin
      for (int b = 1; b < 3; b++) begin
        total++;
        if (got_q[b*BPB].cyc - got_q[b*BPB-1].cyc != 3) begin
          bad++;
          $display("FAIL frame_gap%0d got=%0d exp=3", b, got_q[b*BPB].cyc - got_q[b*BPB-1].cyc);
        end
      end
    end
    d = stream_diff(fi);
    total++;
    if (d != 0) begin bad++; $display("FAIL frame_stream diffs=%0d at beat %0d exp 0", d, fi); end
  endtask

  task automatic test_max_bytes();
    bit to;
    int d, fi;
    start_test();
    for (int i = 0; i < 6; i++) push(8'($urandom));
    build_model();
    wait_idle(1'b0, 300, to);
    total++;
    if (to || rd_cnt != 6) begin
      bad++;
      $display("FAIL max_pops to=%0d got=%0d exp=6", to, rd_cnt);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL max_beats got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    d = stream_diff(fi);
    total++;
    if (d != 0) begin bad++; $display("FAIL max_stream diffs=%0d at beat %0d exp 0", d, fi); end
  endtask

  task automatic test_stall();
    bit to;
    int d, fi;
    start_test();
    bus.tx_ready = 1'b1;
    push(8'hAF);
    build_model();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (got_q.size() >= 1) break;
    end
    bus.tx_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      total++;
      if (bus.tx_valid !== 1'b1 || bus.tx_bit !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d valid=%b bit=%b exp valid=1 bit=0", s, bus.tx_valid, bus.tx_bit);
      end
      @(posedge clk);
      #1;
    end
    bus.tx_ready = 1'b1;
    wait_idle(1'b0, 100, to);
    total++;
    if (to || hold_err != 0 || got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL stall_beats to=%0d holds=%0d got=%0d exp=%0d", to, hold_err,
               got_q.size(), exp_q.size());
    end
    d = stream_diff(fi);
    total++;
    if (d != 0) begin bad++; $display("FAIL stall_stream diffs=%0d at beat %0d exp 0", d, fi); end
  endtask

`ifdef FIFO_TX_PARITY_EN
  task automatic test_parity();
    bit to;
    logic [7:0] vec[2];
    logic       par[2];
    vec[0] = 8'h35; par[0] = 1'b0;
    vec[1] = 8'hE6; par[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_test();
      push(vec[k]);
      wait_idle(1'b0, 100, to);
      total++;
      if (to || got_q.size() != 9) begin
        bad++;
        $display("FAIL parity_beats%0d to=%0d got=%0d exp=9", k, to, got_q.size());
      end else begin
        total++;
        if (got_q[8].b !== par[k] || got_q[8].eof !== 1'b1 || got_q[7].eof !== 1'b0) begin
          bad++;
          $display("FAIL parity_beat%0d bit=%b eof=%b eof7=%b exp bit=%b eof=1 eof7=0", k,
                   got_q[8].b, got_q[8].eof, got_q[7].eof, par[k]);
        end
      end
    end
  endtask
`endif

  task automatic test_mid_reset();
    bit to;
    int d, fi, eofs;
    start_test();
    bus.tx_ready = 1'b1;
    push(8'hAF); push(8'h35);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (got_q.size() >= 4) break;
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.fifo_rd_en, bus.tx_valid, bus.tx_bit, bus.tx_sof, bus.tx_eof, busy} !== 6'b0) begin
      bad++;
      $display("FAIL midrst_outputs got=%b exp=000000",
               {bus.fifo_rd_en, bus.tx_valid, bus.tx_bit, bus.tx_sof, bus.tx_eof, busy});
    end
    eofs = 0;
    foreach (got_q[i]) if (got_q[i].eof === 1'b1) eofs++;
    total++;
    if (eofs != 0 || got_q.size() != 4 || fifo_q.size() != 1) begin
      bad++;
      $display("FAIL midrst_partial eofs=%0d beats=%0d queued=%0d exp 0/4/1", eofs,
               got_q.size(), fifo_q.size());
    end
    @(posedge clk);
    #1 reset = 1'b0;
    got_q.delete();
    model_q.delete();
    model_q.push_back(8'h35);
    build_model();
    wait_idle(1'b0, 100, to);
    total++;
    if (to || got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL midrst_next to=%0d got=%0d exp=%0d", to, got_q.size(), exp_q.size());
    end
    d = stream_diff(fi);
    total++;
    if (d != 0) begin bad++; $display("FAIL midrst_stream diffs=%0d at beat %0d exp 0", d, fi); end
  endtask

  task automatic test_random();
    bit to;
    int d, fi, n;
    for (int it = 0; it < 10; it++) begin
      start_test();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) push(8'($urandom));
      build_model();
      wait_idle(1'b1, 2000, to);
      total++;
      if (to || hold_err != 0 || rd_cnt != n || got_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rand%0d to=%0d holds=%0d pops=%0d/%0d beats=%0d/%0d", it, to, hold_err,
                 rd_cnt, n, got_q.size(), exp_q.size());
      end
      d = stream_diff(fi);
      total++;
      if (d != 0) begin bad++; $display("FAIL rand%0d_stream diffs=%0d at beat %0d exp 0", it, d, fi); end
    end
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    test_reset();
    test_single();
    test_frame();
    test_max_bytes();
    test_stall();
`ifdef FIFO_TX_PARITY_EN
    test_parity();
`endif
    test_mid_reset();
    test_random();
    total++;
    if (rd_empty != 0) begin
      bad++;
      $display("FAIL pop_while_empty got=%0d exp=0", rd_empty);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
